trap_filter_ctrl: RTL and testbench
===================================

# trap_filter_ctrl

Sequencer and configuration controller for the trapezoidal shaping filter. Accepts runtime shaping parameters (rise k, flat-top l, pole-zero M) through a valid/ready handshake. Holds the filter's parameter inputs stable, flushes its delay lines on every reconfiguration and gates ADC samples into it. Asserts an output-valid qualifier only once the filter response is fully settled.

## Interface
- DATA_W, default SIZE_ADC_DATA (package_settings): ADC sample width.
- KL_W, default 8: width of k and l fields; maximum delay 2^KL_W-1.
- M_W, default 16: width of pole-zero multiplier M.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- run  in  1  level; 1 = process samples, 0 = go idle.
- adc_data  in  DATA_W  raw ADC sample, one per cycle.
- adc_valid  in  1  adc_data qualifier.
- cfg_valid  in  1  new parameter set offered.
- cfg_k  in  KL_W  rise time k.
- cfg_l  in  KL_W  delay l.
- cfg_m  in  M_W  multiplier M.
- cfg_ready  out  1  controller can accept a parameter set.
- cfg_err  out  1  one-cycle pulse: offered set rejected.
- flt_k / flt_l  out  KL_W  registered parameters to filter.
- flt_m  out  M_W  registered multiplier to filter.
- flt_clr  out  1  synchronous clear of filter delay lines/accumulators.
- flt_din  out  DATA_W  sample fed to filter (zero while flushing).
- flt_en  out  1  filter clock-enable.
- out_valid  out  1  filter output is settled and usable.
- state  out  2  current FSM state (debug).

## Operation
- FSM states: IDLE=0, FLUSH=1, SETTLE=2, RUN=3.
- Parameter registers P={k,l,M} reset to k=1, l=2, M=0.
- Handshake: transfer when cfg_valid && cfg_ready. cfg_ready=1 in IDLE, SETTLE and RUN, and 0 in FLUSH. cfg_valid may stay high while cfg_ready is low; the set is taken on the first ready cycle.
- Accepted legal set: P updated next cycle, FSM goes to FLUSH from any state.
- IDLE: flt_en=0, out_valid=0. run=1 -> FLUSH.
- FLUSH: flt_clr=1 on the first cycle; flt_en=1, flt_din=0. Counter loads L+K (=l+k, width KL_W+1) and runs L+K cycles, then SETTLE.
- SETTLE: flt_din=adc_data, flt_en=adc_valid. Counter reloads l+k and decrements per adc_valid cycle; at zero -> RUN.
- RUN: flt_din=adc_data, flt_en=adc_valid, out_valid=adc_valid delayed by one cycle (matches filter register stage).
- run=0 in any state -> IDLE next cycle; counter cleared; P retained.
- A legal cfg and run=0 in the same cycle: P updated, FSM goes to IDLE (run has priority for the state).
- Counter never wraps; all compares are unsigned on KL_W+1 bits.

## Timing
- Reset values: cfg_ready=0, cfg_err=0, flt_clr=0, flt_en=0, flt_din=0, out_valid=0, state=IDLE, flt_k=1, flt_l=2, flt_m=0. cfg_ready goes to 1 the cycle after reset deasserts.
- Reset asserted mid-operation aborts any state in one cycle, and P returns to reset values.
- cfg accept to flt_k/flt_l/flt_m updated: 1 cycle. cfg accept to flt_clr high: 1 cycle.
- run rise to first out_valid, with continuous adc_valid: 1 (IDLE->FLUSH) + (l+k) + (l+k) + 1 cycles.
- cfg_err pulses the cycle after the offending handshake. cfg_ready stays 1 and P is unchanged.

## Configuration
- TRAP_CTRL_PARAM_CHECK_EN defined: a set is rejected (cfg_err) if k=0, l<k, or l+k exceeds 2^KL_W-1.
- TRAP_CTRL_PARAM_CHECK_EN undefined: every set is accepted, and cfg_err is tied to 0.

## Test plan
- Reset then run=1, default P (k=1, l=2), adc_valid always 1 -> FLUSH 3 cycles, SETTLE 3 cycles, first out_valid 8 cycles after run rise; flt_din=0 throughout FLUSH.
- In RUN, cfg k=4, l=10, M=300 -> flt_* updated after 1 cycle, flt_clr one pulse, FLUSH 14 cycles, cfg_ready=0 for those 14 cycles, out_valid=0 until SETTLE completes.
- With check enabled, cfg k=5, l=3 -> cfg_err single pulse, P still k=4, l=10, state unchanged; with check disabled -> accepted and FSM goes to FLUSH.
- In SETTLE, toggle adc_valid 1/0 -> counter decrements only on valid cycles; SETTLE lasts 2*(l+k) cycles for 50% duty.
- run=0 mid-FLUSH -> IDLE next cycle, flt_en=0, out_valid=0; run=1 again -> full FLUSH restarts from l+k.
- Assert reset for 1 cycle in RUN with P=(4,10,300) -> all outputs at reset values, flt_k=1, flt_l=2, flt_m=0.

Source files
------------

// File: rtl/trap_filter_ctrl_if.sv
// trap_filter_ctrl_if
//   Runtime parameter-set handshake for the trapezoidal filter controller.
//   master : parameter source (drives cfg_valid/cfg_k/cfg_l/cfg_m,
//            observes cfg_ready/cfg_err)
//   slave  : trap_filter_ctrl
//   cfg_valid  new parameter set offered
//   cfg_k      rise time k           (KL_W bits)
//   cfg_l      flat-top delay l      (KL_W bits)
//   cfg_m      pole-zero multiplier  (M_W bits)
//   cfg_ready  controller can take a set this cycle
//   cfg_err    one-cycle pulse, previous offered set was rejected
interface trap_filter_ctrl_if #(
    parameter int KL_W = 8,
    parameter int M_W  = 16
) ();
    logic            cfg_valid;
    logic [KL_W-1:0] cfg_k;
    logic [KL_W-1:0] cfg_l;
    logic [M_W-1:0]  cfg_m;
    logic            cfg_ready;
    logic            cfg_err;

    modport master (
        output cfg_valid, cfg_k, cfg_l, cfg_m,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_k, cfg_l, cfg_m,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/trap_filter_ctrl.sv
// trap_filter_ctrl
//   Sequencer/configuration controller for the trapezoidal shaping filter.
//   Holds the filter parameters {k, l, M}, flushes the filter delay lines on
//   every reconfiguration or restart, gates ADC samples into the filter and
//   qualifies the filter output once its response has settled.
//
//   Optional feature macro: TRAP_CTRL_PARAM_CHECK_EN
//     defined   : sets with k=0, l<k or l+k > 2^KL_W-1 are rejected (cfg_err)
//     undefined : every set is accepted, cfg_err is tied low
//
//   Ports
//     clk        system clock
//     reset      synchronous, active-low reset
//     run        level: 1 = process samples, 0 = go idle
//     adc_data   raw ADC sample (DATA_W)
//     adc_valid  adc_data qualifier
//     cfg        parameter handshake (trap_filter_ctrl_if.slave)
//     flt_k/l/m  registered parameters to the filter
//     flt_clr    synchronous clear of filter delay lines/accumulators
//     flt_din    sample fed to filter (zero while flushing)
//     flt_en     filter clock-enable
//     out_valid  filter output settled and usable
//     state      FSM state (IDLE=0, FLUSH=1, SETTLE=2, RUN=3)
module trap_filter_ctrl #(
    parameter int DATA_W = 14,  // matches SIZE_ADC_DATA of package_settings
    parameter int KL_W   = 8,
    parameter int M_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    trap_filter_ctrl_if.slave cfg,
    output logic [KL_W-1:0]   flt_k,
    output logic [KL_W-1:0]   flt_l,
    output logic [M_W-1:0]    flt_m,
    output logic              flt_clr,
    output logic [DATA_W-1:0] flt_din,
    output logic              flt_en,
    output logic              out_valid,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLUSH  = 2'd1,
        SETTLE = 2'd2,
        RUN    = 2'd3
    } state_t;

    state_t          st_q, st_d;
    logic [KL_W:0]   cnt_q, cnt_d;
    logic            rdy_q;      // low only during/just after reset
    logic            clr_q;
    logic            ov_q;
    logic            accept;
    logic            legal;
    logic            take;
    logic [KL_W:0]   cfg_span;
    logic [KL_W:0]   span;

    assign cfg.cfg_ready = rdy_q && (st_q != FLUSH);
    assign accept        = cfg.cfg_valid && cfg.cfg_ready;
    assign cfg_span      = {1'b0, cfg.cfg_l} + {1'b0, cfg.cfg_k};

`ifdef TRAP_CTRL_PARAM_CHECK_EN
    logic err_q;

    assign legal = (cfg.cfg_k != '0) && (cfg.cfg_l >= cfg.cfg_k) &&
                   (cfg_span <= {1'b0, {KL_W{1'b1}}});
    assign cfg.cfg_err = err_q;

    always_ff @(posedge clk) begin
        if (!reset) err_q <= 1'b0;
        else        err_q <= accept && !legal;
    end
`else
    assign legal       = 1'b1;
    assign cfg.cfg_err = 1'b0;
`endif

    assign take = accept && legal;

    // Counter load always uses the set that will be in force next cycle, so a
    // flush started by an accepted set is sized by that new set.
    assign span = take ? cfg_span : ({1'b0, flt_l} + {1'b0, flt_k});

    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        if (!run) begin
            st_d  = IDLE;
            cnt_d = '0;
        end else if (take) begin
            st_d  = FLUSH;
            cnt_d = span;
        end else begin
            case (st_q)
                IDLE: begin
                    st_d  = FLUSH;
                    cnt_d = span;
                end
                FLUSH: begin
                    // <= 1 so a zero span still spends exactly one cycle here
                    if (cnt_q <= (KL_W+1)'(1)) begin
                        st_d  = SETTLE;
                        cnt_d = span;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt_q == '0) begin
                        st_d = RUN;
                    end else if (adc_valid) begin
                        if (cnt_q == (KL_W+1)'(1)) begin
                            st_d  = RUN;
                            cnt_d = '0;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end
                RUN: begin
                    cnt_d = '0;
                end
                default: begin
                    st_d  = IDLE;
                    cnt_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        flt_en  = 1'b0;
        flt_din = '0;
        case (st_q)
            FLUSH: flt_en = 1'b1;
            SETTLE, RUN: begin
                flt_en  = adc_valid;
                flt_din = adc_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            st_q  <= IDLE;
            cnt_q <= '0;
            rdy_q <= 1'b0;
            clr_q <= 1'b0;
            ov_q  <= 1'b0;
            flt_k <= KL_W'(1);
            flt_l <= KL_W'(2);
            flt_m <= '0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            rdy_q <= 1'b1;
            clr_q <= (st_d == FLUSH) && (st_q != FLUSH);
            // only samples that stay in RUN are qualified; a restart drops
            // the pending one so out_valid never shows during a flush
            ov_q  <= (st_q == RUN) && (st_d == RUN) && adc_valid;
            if (take) begin
                flt_k <= cfg.cfg_k;
                flt_l <= cfg.cfg_l;
                flt_m <= cfg.cfg_m;
            end
        end
    end

    assign flt_clr   = clr_q;
    assign out_valid = ov_q;
    assign state     = st_q;

endmodule

// File: tb/tb_trap_filter_ctrl.sv
// tb_trap_filter_ctrl
//   Directed scenarios followed by randomized stimulus; every cycle the DUT
//   outputs are compared with a phase/progress reference model of the
//   controller. Build with +define+TRAP_CTRL_PARAM_CHECK_EN for the
//   parameter-check variant.
module tb_trap_filter_ctrl;

    localparam int DATA_W = 14;
    localparam int KL_W   = 8;
    localparam int M_W    = 16;
`ifdef TRAP_CTRL_PARAM_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic              run;
    logic [DATA_W-1:0] adc_data;
    logic              adc_valid;
    logic [KL_W-1:0]   flt_k;
    logic [KL_W-1:0]   flt_l;
    logic [M_W-1:0]    flt_m;
    logic              flt_clr;
    logic [DATA_W-1:0] flt_din;
    logic              flt_en;
    logic              out_valid;
    logic [1:0]        state;

    trap_filter_ctrl_if #(.KL_W(KL_W), .M_W(M_W)) cfg_if ();

    trap_filter_ctrl #(.DATA_W(DATA_W), .KL_W(KL_W), .M_W(M_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .adc_data  (adc_data),
        .adc_valid (adc_valid),
        .cfg       (cfg_if),
        .flt_k     (flt_k),
        .flt_l     (flt_l),
        .flt_m     (flt_m),
        .flt_clr   (flt_clr),
        .flt_din   (flt_din),
        .flt_en    (flt_en),
        .out_valid (out_valid),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 flush, 2 settle, 3 run. m_prog counts
    // flush cycles done (phase 1) or valid samples seen (phase 2) against m_n.
    int m_mode = 0;
    int m_n    = 0;
    int m_prog = 0;
    int m_k    = 1;
    int m_l    = 2;
    int m_m    = 0;
    bit m_rdy  = 1'b0;
    bit m_clr  = 1'b0;
    bit m_err  = 1'b0;
    bit m_ov   = 1'b0;
    bit chk_on = 1'b0;

    function automatic bit legal_set(input int k, input int l);
        bit ok;
        ok = 1'b1;
        if (CHECK_EN) ok = (k != 0) && (l >= k) && (l + k <= (1 << KL_W) - 1);
        return ok;
    endfunction

    task automatic compare_all();
        check("state",     32'(state),            32'(m_mode));
        check("cfg_ready", 32'(cfg_if.cfg_ready), 32'(m_rdy && m_mode != 1));
        check("cfg_err",   32'(cfg_if.cfg_err),   32'(m_err));
        check("flt_clr",   32'(flt_clr),          32'(m_clr));
        check("flt_en",    32'(flt_en),
              (m_mode == 1) ? 32'd1 : (m_mode >= 2) ? 32'(adc_valid) : 32'd0);
        check("flt_din",   32'(flt_din),          (m_mode >= 2) ? 32'(adc_data) : 32'd0);
        check("out_valid", 32'(out_valid),        32'(m_ov));
        check("flt_k",     32'(flt_k),            32'(m_k));
        check("flt_l",     32'(flt_l),            32'(m_l));
        check("flt_m",     32'(flt_m),            32'(m_m));
    endtask

    task automatic model_step();
        bit acc, ok;
        int nm;
        if (!reset) begin
            m_mode = 0; m_n = 0; m_prog = 0;
            m_k = 1; m_l = 2; m_m = 0;
            m_rdy = 1'b0; m_clr = 1'b0; m_err = 1'b0; m_ov = 1'b0;
            return;
        end
        acc = cfg_if.cfg_valid && m_rdy && (m_mode != 1);
        ok  = legal_set(int'(cfg_if.cfg_k), int'(cfg_if.cfg_l));
        if (acc && ok) begin
            m_k = int'(cfg_if.cfg_k);
            m_l = int'(cfg_if.cfg_l);
            m_m = int'(cfg_if.cfg_m);
        end
        nm = m_mode;
        if (!run) begin
            nm = 0;
        end else if ((acc && ok) || m_mode == 0) begin
            nm = 1; m_n = m_k + m_l; m_prog = 0;
        end else if (m_mode == 1) begin
            m_prog++;
            if (m_prog >= m_n) begin nm = 2; m_prog = 0; end
        end else if (m_mode == 2) begin
            if (adc_valid) m_prog++;
            if (m_prog >= m_n) nm = 3;
        end
        m_ov   = (m_mode == 3) && (nm == 3) && adc_valid;
        m_clr  = (nm == 1) && (m_mode != 1);
        m_err  = acc && !ok;
        m_rdy  = 1'b1;
        m_mode = nm;
    endtask

    // One clock: drive at the falling edge, compare 1 ns later, then advance
    // the model to what the coming rising edge should produce.
    task automatic cyc(input bit rst_n, input bit r, input bit av,
                       input bit cv, input int k, input int l, input int m);
        @(negedge clk);
        reset            = rst_n;
        run              = r;
        adc_valid        = av;
        adc_data         = DATA_W'($urandom);
        cfg_if.cfg_valid = cv;
        cfg_if.cfg_k     = KL_W'(k);
        cfg_if.cfg_l     = KL_W'(l);
        cfg_if.cfg_m     = M_W'(m);
        #1;
        if (chk_on) compare_all();
        model_step();
        chk_on = 1'b1;
    endtask

    initial begin
        int lat;
        int k, l;
        reset = 1'b0; run = 1'b0; adc_valid = 1'b0; adc_data = '0;
        cfg_if.cfg_valid = 1'b0; cfg_if.cfg_k = '0; cfg_if.cfg_l = '0; cfg_if.cfg_m = '0;

        // reset, then idle with run low
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0);
        repeat (2) cyc(1, 0, 1, 0, 0, 0, 0);

        // default set: first out_valid 8 cycles after run rises
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            cyc(1, 1, 1, 0, 0, 0, 0);
            if (lat < 0 && out_valid === 1'b1) lat = i;
        end
        check("run_to_out_valid", 32'(lat), 32'd8);

        // reconfigure in RUN
        cyc(1, 1, 1, 1, 4, 10, 300);
        repeat (40) cyc(1, 1, 1, 0, 0, 0, 0);

        // illegal set (accepted when the check is disabled)
        cyc(1, 1, 1, 1, 5, 3, 77);
        repeat (20) cyc(1, 1, 1, 0, 0, 0, 0);

        // settle with 50% adc_valid duty
        cyc(1, 1, 1, 1, 4, 10, 300);
        repeat (14) cyc(1, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) cyc(1, 1, (i % 2) == 0, 0, 0, 0, 0);

        // run dropped mid-flush, then restart
        cyc(1, 1, 1, 1, 3, 6, 12);
        repeat (4) cyc(1, 1, 1, 0, 0, 0, 0);
        repeat (2) cyc(1, 0, 1, 0, 0, 0, 0);
        repeat (30) cyc(1, 1, 1, 0, 0, 0, 0);

        // legal set with run low in the same cycle
        cyc(1, 0, 1, 1, 2, 2, 5);
        repeat (3) cyc(1, 0, 1, 0, 0, 0, 0);

        // one-cycle reset while in RUN with (4,10,300)
        cyc(1, 1, 1, 1, 4, 10, 300);
        repeat (40) cyc(1, 1, 1, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0, 0);
        repeat (10) cyc(1, 1, 1, 0, 0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                k = $urandom_range(0, 60);
                l = $urandom_range(200, 255);
            end else begin
                k = $urandom_range(0, 6);
                l = $urandom_range(0, 14);
            end
            cyc($urandom_range(0, 299) != 0,
                $urandom_range(0, 49) != 0,
                $urandom_range(0, 3) != 0,
                $urandom_range(0, 9) == 0,
                k, l, int'($urandom_range(0, 65535)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
